// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: load-use bubbles, mispredict flushes, data-memory wait freeze.
// Optional HAZ_PERF_CNT_EN adds stall_cycles / flush_events performance counters.
module pipe_hazard_ctrl #(
   parameter int FLUSH_CYCLES = 1,
   parameter int MAX_WAIT     = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs1_addr,
   input  logic [4:0]  id_rs2_addr,
   input  logic        id_uses_rs2,
   input  logic [4:0]  ex_rd,
   input  logic        ex_memread,
   input  logic        ex_mispredict,
   input  logic        mem_busy,
   output logic        pc_en,
   output logic        if_id_en,
   output logic        id_ex_en,
   output logic        ex_mem_en,
   output logic        mem_wb_en,
   output logic        if_id_flush,
   output logic        id_ex_flush,
   output logic        ex_mem_flush,
   output logic        mem_timeout,
   output logic [1:0]  ctrl_state
`ifdef HAZ_PERF_CNT_EN
   ,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_events
`endif
);

   localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam int WCW = 16;

   typedef enum logic [1:0] {
      RUN           = 2'd0,
      FLUSH         = 2'd1,
      MEM_WAIT      = 2'd2,
      REDIRECT_PEND = 2'd3
   } state_t;

   state_t           state_reg, state_next;
   logic [FCW-1:0]   flush_cnt_reg, flush_cnt_next;
   logic [WCW-1:0]   wait_cnt_reg, wait_cnt_next;
   logic             pend_reg, pend_next;
   logic             timeout_reg, timeout_next;

   logic             load_use;
   logic             service;
   logic             wait_at_max;

   assign load_use = ex_memread && (ex_rd != 5'd0) &&
                     ((ex_rd == id_rs1_addr) || (id_uses_rs2 && (ex_rd == id_rs2_addr)));
   assign service     = !mem_busy && (ex_mispredict || pend_reg);
   assign wait_at_max = (wait_cnt_reg == WCW'(MAX_WAIT));
   assign ctrl_state  = state_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= RUN;
         flush_cnt_reg <= '0;
         wait_cnt_reg  <= '0;
         pend_reg      <= 1'b0;
         timeout_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         flush_cnt_reg <= flush_cnt_next;
         wait_cnt_reg  <= wait_cnt_next;
         pend_reg      <= pend_next;
         timeout_reg   <= timeout_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      flush_cnt_next = flush_cnt_reg;
      pend_next      = pend_reg;
      wait_cnt_next  = '0;
      timeout_next   = timeout_reg;
      pc_en          = 1'b1;
      if_id_en       = 1'b1;
      id_ex_en       = 1'b1;
      ex_mem_en      = 1'b1;
      mem_wb_en      = 1'b1;
      if_id_flush    = 1'b0;
      id_ex_flush    = 1'b0;
      ex_mem_flush   = 1'b0;

      if (mem_busy) begin
         // Full freeze; a mispredict arriving now is remembered and serviced once memory is ready.
         pc_en          = 1'b0;
         if_id_en       = 1'b0;
         id_ex_en       = 1'b0;
         ex_mem_en      = 1'b0;
         mem_wb_en      = 1'b0;
         pend_next      = pend_reg || ex_mispredict;
         state_next     = pend_next ? REDIRECT_PEND : MEM_WAIT;
         wait_cnt_next  = wait_at_max ? wait_cnt_reg : wait_cnt_reg + WCW'(1);
         flush_cnt_next = '0;
         if (wait_at_max) begin
            timeout_next = 1'b1;
         end
      end else if (service) begin
         if_id_flush    = 1'b1;
         id_ex_flush    = 1'b1;
         flush_cnt_next = FCW'(FLUSH_CYCLES - 1);
         pend_next      = 1'b0;
         state_next     = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
      end else if (state_reg == FLUSH) begin
         // ID holds a squashed slot here, so load-use is deliberately not evaluated.
         if_id_flush = 1'b1;
         if (flush_cnt_reg <= FCW'(1)) begin
            flush_cnt_next = '0;
            state_next     = RUN;
         end else begin
            flush_cnt_next = flush_cnt_reg - FCW'(1);
            state_next     = FLUSH;
         end
      end else begin
         state_next = RUN;
         if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
         end
      end

      mem_timeout = timeout_reg || (mem_busy && wait_at_max);

      if (!rst) begin
         pc_en        = 1'b0;
         if_id_en     = 1'b0;
         id_ex_en     = 1'b0;
         ex_mem_en    = 1'b0;
         mem_wb_en    = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         ex_mem_flush = 1'b1;
         mem_timeout  = 1'b0;
      end
   end

`ifdef HAZ_PERF_CNT_EN
   logic [31:0] stall_cycles_reg;
   logic [31:0] flush_events_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cycles_reg <= '0;
         flush_events_reg <= '0;
      end else begin
         if (!pc_en) begin
            stall_cycles_reg <= stall_cycles_reg + 32'd1;
         end
         if (service) begin
            flush_events_reg <= flush_events_reg + 32'd1;
         end
      end
   end

   assign stall_cycles = stall_cycles_reg;
   assign flush_events = flush_events_reg;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios then random traffic vs. a rule-level model.
module tb_pipe_hazard_ctrl;
   localparam int FC = 3;
   localparam int MW = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, id_uses_rs2, ex_memread, ex_mispredict, mem_busy;
   logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd;
   logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
   logic       if_id_flush, id_ex_flush, ex_mem_flush, mem_timeout;
   logic [1:0] ctrl_state;
`ifdef HAZ_PERF_CNT_EN
   logic [31:0] stall_cycles, flush_events;
`endif

   pipe_hazard_ctrl #(.FLUSH_CYCLES(FC), .MAX_WAIT(MW)) dut (
      .clk(clk), .rst(rst),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_uses_rs2(id_uses_rs2),
      .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_mispredict(ex_mispredict), .mem_busy(mem_busy),
      .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
      .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
      .ex_mem_flush(ex_mem_flush), .mem_timeout(mem_timeout), .ctrl_state(ctrl_state)
`ifdef HAZ_PERF_CNT_EN
      , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
   );

   typedef struct packed {
      logic [4:0]  en;   // {pc, if_id, id_ex, ex_mem, mem_wb}
      logic [2:0]  fl;   // {if_id, id_ex, ex_mem}
      logic        to;
      logic [1:0]  st;
      logic [31:0] stalls;
      logic [31:0] flushes;
   } exp_t;

   exp_t exp_q[$];
   int   cyc_q[$];
   int   checks = 0;
   int   failures = 0;
   int   cycle_no = 0;

   // Reference model: squash cycles left, consecutive busy count, pending redirect.
   int          squash_left = 0;
   int          busy_run = 0;
   bit          pending = 0;
   bit          last_busy = 0;
   bit          sticky = 0;
   int unsigned stalls = 0;
   int unsigned flushes = 0;

   task automatic check(input string name, input int cyc, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
      end
   endtask

   task automatic step(input bit r, input bit busy, input bit mis, input bit memread,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2, input bit uses2);
      exp_t e;
      bit   lu;
      @(posedge clk);
      #1;
      rst = r; mem_busy = busy; ex_mispredict = mis; ex_memread = memread;
      ex_rd = rd; id_rs1_addr = rs1; id_rs2_addr = rs2; id_uses_rs2 = uses2;
      cycle_no++;
      if (!r) begin
         squash_left = 0; busy_run = 0; pending = 0; last_busy = 0; sticky = 0;
         stalls = 0; flushes = 0;
         e = '0;
         e.fl = 3'b111;
      end else begin
         e.stalls  = stalls;
         e.flushes = flushes;
         e.st = last_busy ? (pending ? 2'd3 : 2'd2) : (squash_left > 0 ? 2'd1 : 2'd0);
         e.to = sticky || (busy && busy_run == MW);
         lu = memread && rd != 0 && (rd == rs1 || (uses2 && rd == rs2));
         if (busy) begin
            e.en = 5'b00000; e.fl = 3'b000;
            if (busy_run == MW) sticky = 1; else busy_run++;
            pending = pending || mis;
            squash_left = 0;
         end else begin
            busy_run = 0;
            if (mis || pending) begin
               e.en = 5'b11111; e.fl = 3'b110;
               squash_left = FC - 1; pending = 0; flushes++;
            end else if (squash_left > 0) begin
               e.en = 5'b11111; e.fl = 3'b100;
               squash_left--;
            end else if (lu) begin
               e.en = 5'b00111; e.fl = 3'b010;
            end else begin
               e.en = 5'b11111; e.fl = 3'b000;
            end
         end
         if (!e.en[4]) stalls++;
         last_busy = busy;
      end
      exp_q.push_back(e);
      cyc_q.push_back(cycle_no);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
   endtask

   // Monitor: one expected record per cycle, compared mid-cycle.
   initial begin
      exp_t e;
      int   c;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            c = cyc_q.pop_front();
            check("enables", c, {27'd0, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, {27'd0, e.en});
            check("flushes", c, {29'd0, if_id_flush, id_ex_flush, ex_mem_flush}, {29'd0, e.fl});
            check("mem_timeout", c, {31'd0, mem_timeout}, {31'd0, e.to});
            check("ctrl_state", c, {30'd0, ctrl_state}, {30'd0, e.st});
`ifdef HAZ_PERF_CNT_EN
            check("stall_cycles", c, stall_cycles, e.stalls);
            check("flush_events", c, flush_events, e.flushes);
`endif
            $display("cyc=%0d en=%b fl=%b to=%b st=%0d", c, e.en, e.fl, e.to, e.st);
         end
      end
   end

   initial begin
      int busy_left;
      rst = 0; mem_busy = 0; ex_mispredict = 0; ex_memread = 0;
      ex_rd = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_uses_rs2 = 0;

      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      idle(2);
      // load-use on rs1, rs2, rs2 unused, and x0 destination
      step(1, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0);
      idle(1);
      step(1, 0, 0, 1, 5'd7, 5'd1, 5'd7, 1);
      step(1, 0, 0, 1, 5'd7, 5'd1, 5'd7, 0);
      step(1, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1);
      idle(1);
      // mispredict pulse, hazard-looking traffic in the squash window
      step(1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
      step(1, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0);
      idle(3);
      // mispredict on the second of four busy cycles
      step(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      step(1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0);
      step(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      step(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      idle(4);
      // timeout: busy held 20 cycles, sticky afterwards until reset
      for (int i = 0; i < 20; i++) step(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      idle(3);
      step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      idle(2);
      // reset asserted mid-cycle while in FLUSH
      step(1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
      step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      idle(2);

      busy_left = 0;
      for (int i = 0; i < 500; i++) begin
         bit r, b;
         r = ($urandom_range(0, 199) != 0);
         if (busy_left == 0 && $urandom_range(0, 15) == 0) busy_left = $urandom_range(1, 12);
         b = (busy_left > 0);
         if (busy_left > 0) busy_left--;
         step(r, b, ($urandom_range(0, 9) == 0), $urandom_range(0, 1),
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), $urandom_range(0, 1));
      end

      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain got=%0d want=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
